rr_interval_multi_classifier: RTL and testbench

Multi-channel, runtime-configurable successor to the single-channel beat-interval classifier. It measures the beat-to-beat (RR) interval in milliseconds on CH independent channels and classifies each interval as tachy, normal or brady. On top of that it adds a refractory reject window, asystole timeout detection, beat-to-beat irregularity detection, and saturating event counters read through a registered mux. It sits between the per-lead beat detectors and the status/readout logic.

---
 rtl/rr_pkg.sv | 30 +++
 rtl/rr_channel.sv | 156 +++++++++++++++
 rtl/rr_interval_multi_classifier.sv | 85 ++++++++
 tb/tb_rr_interval_multi_classifier.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Purpose: shared types and encodings for the multi-channel RR interval classifier.
// Latency: n/a (definitions only).
// Backpressure: n/a; no flow control in this block.
// Contents: rhythm type codes, per-channel FSM state enum, readout select codes.
package rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ASYS  = 2'd2
    } rr_state_e;

    localparam logic [1:0] TYPE_TACHY  = 2'b00;
    localparam logic [1:0] TYPE_NORMAL = 2'b01;
    localparam logic [1:0] TYPE_BRADY  = 2'b10;
    localparam logic [1:0] TYPE_ASYS   = 2'b11;

    // Readout selects. Values 0..6 double as indices into the counter array.
    localparam logic [2:0] SEL_TOTAL  = 3'd0;
    localparam logic [2:0] SEL_TACHY  = 3'd1;
    localparam logic [2:0] SEL_NORMAL = 3'd2;
    localparam logic [2:0] SEL_BRADY  = 3'd3;
    localparam logic [2:0] SEL_ASYS   = 3'd4;
    localparam logic [2:0] SEL_IRREG  = 3'd5;
    localparam logic [2:0] SEL_REJECT = 3'd6;
    localparam logic [2:0] SEL_LAST   = 3'd7;

    localparam int N_CNT = 7;

endpackage

// File: rtl/rr_channel.sv
// Purpose: one channel of RR interval measurement, classification and event counting.
// Latency: a beat or asystole-reaching tick in cycle t updates outputs/counters in t+1.
// Backpressure: none; every beat and tick is consumed in the cycle it arrives.
// Ports: clk/rst_n (sync, active-low); tick_i 1 ms strobe; beat_i beat strobe;
//        cfg_*_i thresholds; clr_i counter clear; evt_valid_o/type_code_o/irreg_flag_o
//        classification result; cnt_o seven event counters; last_interval_o last accepted interval.
module rr_channel
    import rr_pkg::*;
#(
    parameter int COUNT_W    = 16,
    parameter int MS_W       = 16,
    parameter int REFRACT_MS = 200
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tick_i,
    input  logic                              beat_i,
    input  logic [MS_W-1:0]                   cfg_tachy_ms_i,
    input  logic [MS_W-1:0]                   cfg_brady_ms_i,
    input  logic [MS_W-1:0]                   cfg_irreg_ms_i,
    input  logic [MS_W-1:0]                   cfg_asys_ms_i,
    input  logic                              clr_i,
    output logic                              evt_valid_o,
    output logic [1:0]                        type_code_o,
    output logic                              irreg_flag_o,
    output logic [N_CNT-1:0][COUNT_W-1:0]     cnt_o,
    output logic [MS_W-1:0]                   last_interval_o
);

    localparam logic [MS_W-1:0] REFRACT = MS_W'(REFRACT_MS);

    rr_state_e                       state_q, state_d;
    logic [MS_W-1:0]                 ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0]                 prev_q, prev_d;
    logic                            prev_vld_q, prev_vld_d;
    logic [MS_W-1:0]                 last_q, last_d;
    logic [1:0]                      type_q, type_d;
    logic                            irreg_q, irreg_d;
    logic                            evt_q, evt_d;
    logic [N_CNT-1:0][COUNT_W-1:0]   cnt_q;
    logic [N_CNT-1:0]                inc;

    logic [MS_W-1:0]                 ms_inc;
    logic [MS_W-1:0]                 diff;

    always_comb begin
        ms_inc = (ms_cnt_q == '1) ? ms_cnt_q : ms_cnt_q + 1'b1;
        diff   = (ms_cnt_q >= prev_q) ? (ms_cnt_q - prev_q) : (prev_q - ms_cnt_q);

        state_d    = state_q;
        ms_cnt_d   = ms_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        last_d     = last_q;
        type_d     = type_q;
        irreg_d    = irreg_q;
        evt_d      = 1'b0;
        inc        = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Ticks are ignored until the first beat gives a reference point.
                if (beat_i) begin
                    state_d         = ST_ARMED;
                    ms_cnt_d        = '0;
                    prev_vld_d      = 1'b0;
                    inc[SEL_TOTAL]  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (beat_i && (ms_cnt_q < REFRACT)) begin
                    // Refractory reject: the interval keeps running as if no beat came.
                    inc[SEL_REJECT] = 1'b1;
                    if (tick_i) ms_cnt_d = ms_inc;
                end else if (beat_i) begin
                    // Accepted beat wins over a coincident tick; the pre-tick count is used.
                    last_d         = ms_cnt_q;
                    inc[SEL_TOTAL] = 1'b1;
                    if (ms_cnt_q < cfg_tachy_ms_i) begin
                        type_d         = TYPE_TACHY;
                        inc[SEL_TACHY] = 1'b1;
                    end else if (ms_cnt_q <= cfg_brady_ms_i) begin
                        type_d          = TYPE_NORMAL;
                        inc[SEL_NORMAL] = 1'b1;
                    end else begin
                        type_d         = TYPE_BRADY;
                        inc[SEL_BRADY] = 1'b1;
                    end
                    irreg_d        = prev_vld_q && (diff > cfg_irreg_ms_i);
                    inc[SEL_IRREG] = prev_vld_q && (diff > cfg_irreg_ms_i);
                    prev_d         = ms_cnt_q;
                    prev_vld_d     = 1'b1;
                    ms_cnt_d       = '0;
                    evt_d          = 1'b1;
                end else if (tick_i) begin
                    ms_cnt_d = ms_inc;
                    if (ms_inc == cfg_asys_ms_i) begin
                        state_d       = ST_ASYS;
                        type_d        = TYPE_ASYS;
                        evt_d         = 1'b1;
                        inc[SEL_ASYS] = 1'b1;
                    end
                end
            end
            ST_ASYS: begin
                // Re-arm without classifying: the gap is not a meaningful RR interval.
                if (beat_i) begin
                    state_d        = ST_ARMED;
                    ms_cnt_d       = '0;
                    prev_vld_d     = 1'b0;
                    inc[SEL_TOTAL] = 1'b1;
                end else if (tick_i) begin
                    ms_cnt_d = ms_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ms_cnt_q   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            last_q     <= '0;
            type_q     <= TYPE_NORMAL;
            irreg_q    <= 1'b0;
            evt_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ms_cnt_q   <= ms_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            type_q     <= type_d;
            irreg_q    <= irreg_d;
            evt_q      <= evt_d;
            last_q     <= clr_i ? '0 : last_d;
            for (int i = 0; i < N_CNT; i++) begin
                if (clr_i) begin
                    cnt_q[i] <= '0;
                end else if (inc[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign evt_valid_o     = evt_q;
    assign type_code_o     = type_q;
    assign irreg_flag_o    = irreg_q;
    assign cnt_o           = cnt_q;
    assign last_interval_o = last_q;

endmodule

// File: rtl/rr_interval_multi_classifier.sv
// Purpose: CH independent RR interval classifiers plus a registered counter readout mux.
// Latency: classification 1 cycle after the beat; readout valid 1 cycle after rd_ch/rd_sel.
// Backpressure: none; all channels accept beats every cycle, readout is free-running.
// Ports: clk/rst_n (sync, active-low); tick_1ms shared strobe; beat_pulse per channel;
//        cfg_* thresholds; clr clears all counters; evt_valid/type_code/irreg_flag per channel;
//        rd_ch/rd_sel select a counter or last interval, returned on rd_data.
module rr_interval_multi_classifier
    import rr_pkg::*;
#(
    parameter int  CH         = 2,
    parameter int  COUNT_W    = 16,
    parameter int  MS_W       = 16,
    parameter int  REFRACT_MS = 200,
    localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1,
    localparam int RD_W       = (COUNT_W > MS_W) ? COUNT_W : MS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1ms,
    input  logic [CH-1:0]     beat_pulse,
    input  logic [MS_W-1:0]   cfg_tachy_ms,
    input  logic [MS_W-1:0]   cfg_brady_ms,
    input  logic [MS_W-1:0]   cfg_irreg_ms,
    input  logic [MS_W-1:0]   cfg_asys_ms,
    input  logic              clr,
    output logic [CH-1:0]     evt_valid,
    output logic [2*CH-1:0]   type_code,
    output logic [CH-1:0]     irreg_flag,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [RD_W-1:0]   rd_data
);

    logic [CH-1:0][N_CNT-1:0][COUNT_W-1:0] cnt_w;
    logic [CH-1:0][MS_W-1:0]               last_w;
    logic [RD_W-1:0]                       rd_data_q, rd_data_d;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        rr_channel #(
            .COUNT_W    (COUNT_W),
            .MS_W       (MS_W),
            .REFRACT_MS (REFRACT_MS)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .tick_i          (tick_1ms),
            .beat_i          (beat_pulse[g]),
            .cfg_tachy_ms_i  (cfg_tachy_ms),
            .cfg_brady_ms_i  (cfg_brady_ms),
            .cfg_irreg_ms_i  (cfg_irreg_ms),
            .cfg_asys_ms_i   (cfg_asys_ms),
            .clr_i           (clr),
            .evt_valid_o     (evt_valid[g]),
            .type_code_o     (type_code[2*g +: 2]),
            .irreg_flag_o    (irreg_flag[g]),
            .cnt_o           (cnt_w[g]),
            .last_interval_o (last_w[g])
        );
    end

    // Unpopulated channel indices (CH not a power of two) read back as zero.
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                if (rd_sel == SEL_LAST) begin
                    rd_data_d = RD_W'(last_w[c]);
                end else begin
                    rd_data_d = RD_W'(cnt_w[c][rd_sel]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rr_interval_multi_classifier.sv
module tb_rr_interval_multi_classifier;

    logic        clk;
    logic        rst_n;
    logic        tick_1ms;
    logic [1:0]  beat_pulse;
    logic [15:0] cfg_tachy_ms, cfg_brady_ms, cfg_irreg_ms, cfg_asys_ms;
    logic        clr;
    logic [1:0]  evt_valid;
    logic [3:0]  type_code;
    logic [1:0]  irreg_flag;
    logic [0:0]  rd_ch;
    logic [2:0]  rd_sel;
    logic [15:0] rd_data;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [1:0] t;
        logic       irr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    localparam logic [1:0] T_TACHY = 2'b00, T_NORMAL = 2'b01, T_BRADY = 2'b10, T_ASYS = 2'b11;

    rr_interval_multi_classifier #(
        .CH(2), .COUNT_W(4), .MS_W(16), .REFRACT_MS(200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1ms     (tick_1ms),
        .beat_pulse   (beat_pulse),
        .cfg_tachy_ms (cfg_tachy_ms),
        .cfg_brady_ms (cfg_brady_ms),
        .cfg_irreg_ms (cfg_irreg_ms),
        .cfg_asys_ms  (cfg_asys_ms),
        .clr          (clr),
        .evt_valid    (evt_valid),
        .type_code    (type_code),
        .irreg_flag   (irreg_flag),
        .rd_ch        (rd_ch),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One clock cycle of stimulus, driven just after the rising edge.
    task automatic cyc(input logic t, input logic [1:0] b, input logic c);
        tick_1ms   = t;
        beat_pulse = b;
        clr        = c;
        @(posedge clk);
        #1;
        tick_1ms   = 1'b0;
        beat_pulse = 2'b00;
        clr        = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 2'b00, 1'b0);
            cyc(1'b0, 2'b00, 1'b0);
        end
    endtask

    task automatic rd(input logic ch, input logic [2:0] sel, input logic [15:0] e, input string tag);
        rd_ch  = ch;
        rd_sel = sel;
        cyc(1'b0, 2'b00, 1'b0);
        #3;
        chk(tag, rd_data, e);
    endtask

    task automatic push(input int c, input logic [1:0] t, input logic irr);
        exp_t e;
        e.t   = t;
        e.irr = irr;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk_evt(input int c);
        exp_t e;
        int   have;
        have = 0;
        e    = '0;
        if (c == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
        end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
        end
        chk($sformatf("evt_expected_ch%0d", c), have, 1);
        if (have != 0)
            chk($sformatf("evt_type_irr_ch%0d", c), {type_code[2*c +: 2], irreg_flag[c]}, {e.t, e.irr});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (evt_valid[0]) chk_evt(0);
            if (evt_valid[1]) chk_evt(1);
        end
    end

    initial begin
        rst_n        = 1'b0;
        tick_1ms     = 1'b0;
        beat_pulse   = 2'b00;
        clr          = 1'b0;
        rd_ch        = 1'b0;
        rd_sel       = 3'd0;
        cfg_tachy_ms = 16'd600;
        cfg_brady_ms = 16'd1000;
        cfg_irreg_ms = 16'd150;
        cfg_asys_ms  = 16'd3000;

        repeat (3) @(posedge clk);
        #4;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_type_code", type_code, 4'b0101);
        chk("rst_irreg", irreg_flag, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic sequence: arm, then 800 / 500 / 1200 ms intervals.
        cyc(1'b0, 2'b01, 1'b0);
        ticks(800);  push(0, T_NORMAL, 1'b0); cyc(1'b0, 2'b01, 1'b0);
        ticks(500);  push(0, T_TACHY, 1'b1);  cyc(1'b0, 2'b01, 1'b0);
        ticks(1200); push(0, T_BRADY, 1'b1);  cyc(1'b0, 2'b01, 1'b0);
        rd(1'b0, 3'd0, 16'd4, "ch0_total_4");
        rd(1'b0, 3'd1, 16'd1, "ch0_tachy_1");
        rd(1'b0, 3'd2, 16'd1, "ch0_normal_1");
        rd(1'b0, 3'd3, 16'd1, "ch0_brady_1");
        rd(1'b0, 3'd5, 16'd2, "ch0_irreg_2");
        rd(1'b0, 3'd7, 16'd1200, "ch0_last_1200");

        // Refractory reject at 100 ms, then accepted beat at 800 ms.
        ticks(100); cyc(1'b0, 2'b01, 1'b0);
        ticks(700); push(0, T_NORMAL, 1'b1); cyc(1'b0, 2'b01, 1'b0);
        rd(1'b0, 3'd6, 16'd1, "ch0_rejected_1");
        rd(1'b0, 3'd0, 16'd5, "ch0_total_5");

        // Asystole after 3000 ms silence.
        ticks(2999);
        push(0, T_ASYS, 1'b1);
        cyc(1'b1, 2'b00, 1'b0);
        #3;
        chk("asys_evt_timing", {evt_valid[0], type_code[1:0]}, 3'b111);
        cyc(1'b0, 2'b00, 1'b0);
        rd(1'b0, 3'd4, 16'd1, "ch0_asys_1");
        cyc(1'b0, 2'b01, 1'b0);
        #3;
        chk("asys_type_holds", type_code[1:0], T_ASYS);
        ticks(800); push(0, T_NORMAL, 1'b0); cyc(1'b0, 2'b01, 1'b0);

        // Coincident tick+beat at 599, then boundary intervals.
        ticks(599);  push(0, T_TACHY, 1'b1);  cyc(1'b1, 2'b01, 1'b0);
        rd(1'b0, 3'd7, 16'd599, "ch0_last_599");
        ticks(600);  push(0, T_NORMAL, 1'b0); cyc(1'b0, 2'b01, 1'b0);
        ticks(1000); push(0, T_NORMAL, 1'b1); cyc(1'b0, 2'b01, 1'b0);
        ticks(1001); push(0, T_BRADY, 1'b0);  cyc(1'b0, 2'b01, 1'b0);
        rd(1'b0, 3'd7, 16'd1001, "ch0_last_1001");
        rd(1'b0, 3'd2, 16'd5, "ch0_normal_5");
        rd(1'b0, 3'd3, 16'd2, "ch0_brady_2");
        rd(1'b0, 3'd0, 16'd11, "ch0_total_11");

        // Saturation of 4-bit counters.
        for (int i = 0; i < 14; i++) begin
            ticks(300);
            push(0, T_TACHY, (i == 0));
            cyc(1'b0, 2'b01, 1'b0);
        end
        rd(1'b0, 3'd1, 16'd15, "ch0_tachy_sat");
        rd(1'b0, 3'd0, 16'd15, "ch0_total_sat");
        rd(1'b0, 3'd5, 16'd6, "ch0_irreg_6");

        // Clear coincident with an accepted beat.
        ticks(300); push(0, T_TACHY, 1'b0); cyc(1'b0, 2'b01, 1'b1);
        rd(1'b0, 3'd1, 16'd0, "clr_tachy_0");
        rd(1'b0, 3'd0, 16'd0, "clr_total_0");
        rd(1'b0, 3'd5, 16'd0, "clr_irreg_0");

        // Two channels beating in the same cycle with different intervals.
        ticks(450);
        cyc(1'b0, 2'b10, 1'b0);
        ticks(250);
        push(0, T_NORMAL, 1'b1);
        push(1, T_TACHY, 1'b0);
        cyc(1'b0, 2'b11, 1'b0);
        rd(1'b1, 3'd7, 16'd250, "ch1_last_250");
        rd(1'b0, 3'd7, 16'd700, "ch0_last_700");
        rd(1'b1, 3'd0, 16'd2, "ch1_total_2");
        rd(1'b1, 3'd1, 16'd1, "ch1_tachy_1");

        // Reset mid-operation.
        ticks(100);
        rst_n = 1'b0;
        cyc(1'b0, 2'b11, 1'b0);
        #3;
        chk("midrst_evt", evt_valid, 0);
        chk("midrst_type", type_code, 4'b0101);
        chk("midrst_rd", rd_data, 0);
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
